// File: rtl/port_rx_frame_buf.sv
// Per-port receive frame buffer: MAC byte stream -> byte FIFO + 16-bit descriptor FIFO.
// Latency: descriptor written one clock after in_last, visible one clock later; FIFO reads 1 clock.
// Backpressure: none on input; frames lacking space at first byte are dropped whole (stat_drop).
//
// Optional build macro RX_FCS_CHECK_EN adds a CRC-32 residue check that sets descriptor bit15.
module port_rx_frame_buf #(
  parameter int DATA_AW = 12,
  parameter int PTR_AW  = 5,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_err,
  input  logic        data_fifo_rd,
  output logic [7:0]  data_fifo_dout,
  input  logic        ptr_fifo_rd,
  output logic [15:0] ptr_fifo_dout,
  output logic        ptr_fifo_empty,
  output logic        stat_drop,
  output logic        stat_err
);

  localparam int DATA_DEPTH = 1 << DATA_AW;
  localparam int PTR_DEPTH  = 1 << PTR_AW;
  localparam logic [DATA_AW:0] DATA_FULL = {1'b1, {DATA_AW{1'b0}}};
  localparam logic [PTR_AW:0]  PTR_FULL  = {1'b1, {PTR_AW{1'b0}}};
  localparam logic [DATA_AW:0] MAX_FREE  = (DATA_AW+1)'(MAX_LEN);
  localparam logic [PTR_AW:0]  PTR_MIN   = (PTR_AW+1)'(2);
  localparam logic [12:0]      MAX_L     = 13'(MAX_LEN);
  localparam logic [12:0]      MIN_L     = 13'(MIN_LEN);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t state, state_nxt;

  // Storage
  logic [7:0]  dmem [0:DATA_DEPTH-1];
  logic [15:0] pmem [0:PTR_DEPTH-1];

  logic [DATA_AW-1:0] d_wp, d_rp;
  logic [DATA_AW:0]   d_cnt, d_free;
  logic [PTR_AW-1:0]  p_wp, p_rp;
  logic [PTR_AW:0]    p_cnt, p_free;

  // Per-frame tracking
  logic [12:0] len, len_nxt;
  logic        err, err_nxt;
  logic        giant, giant_nxt;

  logic        space_ok;
  logic        byte_ok;
  logic        d_wr;
  logic        d_rd_ok;
  logic        p_rd_ok;
  logic        commit_ld;
  logic [15:0] desc_nxt;
  logic        drop_ld;
  logic        commit_pend;
  logic [15:0] commit_desc;
  logic        fcs_bad;

  // Free space; bytes of an in-flight frame are already in d_cnt, and the
  // "two descriptor slots" rule covers a commit still sitting in commit_pend.
  assign d_free   = DATA_FULL - d_cnt;
  assign p_free   = PTR_FULL - p_cnt;
  assign space_ok = (d_free >= MAX_FREE) && (p_free >= PTR_MIN);

  // Whether a valid byte this cycle would be stored (independent of the FSM block
  // so the CRC path does not loop back through it).
  assign byte_ok = (state == IDLE) ? space_ok : ((state == RECV) && (len < MAX_L));

  assign d_rd_ok        = data_fifo_rd && (d_cnt != '0);
  assign p_rd_ok        = ptr_fifo_rd && (p_cnt != '0);
  assign ptr_fifo_empty = (p_cnt == '0);

`ifdef RX_FCS_CHECK_EN
  logic [31:0] crc, crc_base, crc_upd, crc_nxt;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Reflected CRC over stored bytes only; a giant's dropped tail is excluded.
  assign crc_base = (state == IDLE) ? 32'hFFFFFFFF : crc;
  assign crc_upd  = crc_byte(crc_base, in_data);
  assign crc_nxt  = byte_ok ? crc_upd : crc_base;
  // The reflected register holds 0xDEBB20E3 after a good FCS; compare in normal bit order.
  assign fcs_bad  = (bitrev32(crc_nxt) != 32'hC704DD7B);

  // Running CRC of the current frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc <= 32'hFFFFFFFF;
    end else if (in_valid) begin
      crc <= crc_nxt;
    end
  end
`else
  assign fcs_bad = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state, byte write enable and descriptor build
  always_comb begin
    state_nxt = state;
    d_wr      = 1'b0;
    commit_ld = 1'b0;
    drop_ld   = 1'b0;
    desc_nxt  = '0;
    len_nxt   = len;
    err_nxt   = err;
    giant_nxt = giant;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (space_ok) begin
            d_wr      = 1'b1;
            len_nxt   = 13'd1;
            err_nxt   = in_err;
            giant_nxt = 1'b0;
            if (in_last) begin
              commit_ld = 1'b1;
              desc_nxt  = {in_err | fcs_bad, 1'b1, 1'b0, 13'd1};
            end else begin
              state_nxt = RECV;
            end
          end else begin
            drop_ld = 1'b1;
            if (!in_last) begin
              state_nxt = DROP;
            end
          end
        end
      end
      RECV: begin
        if (in_valid) begin
          d_wr      = byte_ok;
          len_nxt   = len + {12'h0, byte_ok};
          err_nxt   = err | in_err;
          giant_nxt = giant | ~byte_ok;
          if (in_last) begin
            commit_ld = 1'b1;
            desc_nxt  = {err_nxt | fcs_bad, (len_nxt < MIN_L) | giant_nxt, 1'b0, len_nxt};
            state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (in_valid && in_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-frame length / error / giant tracking
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len   <= '0;
      err   <= 1'b0;
      giant <= 1'b0;
    end else begin
      len   <= len_nxt;
      err   <= err_nxt;
      giant <= giant_nxt;
    end
  end

  // Registered descriptor commit plus status pulses aligned with the write
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      commit_pend <= 1'b0;
      commit_desc <= '0;
      stat_err    <= 1'b0;
      stat_drop   <= 1'b0;
    end else begin
      commit_pend <= commit_ld;
      if (commit_ld) begin
        commit_desc <= desc_nxt;
      end
      stat_err  <= commit_ld & (desc_nxt[15] | desc_nxt[14]);
      stat_drop <= drop_ld;
    end
  end

  // Data FIFO storage write
  always_ff @(posedge clk) begin
    if (d_wr) begin
      dmem[d_wp] <= in_data;
    end
  end

  // Data FIFO pointers, occupancy and registered read data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_wp           <= '0;
      d_rp           <= '0;
      d_cnt          <= '0;
      data_fifo_dout <= '0;
    end else begin
      if (d_wr) begin
        d_wp <= d_wp + 1'b1;
      end
      if (d_rd_ok) begin
        d_rp           <= d_rp + 1'b1;
        data_fifo_dout <= dmem[d_rp];
      end
      d_cnt <= d_cnt + {{DATA_AW{1'b0}}, d_wr} - {{DATA_AW{1'b0}}, d_rd_ok};
    end
  end

  // Pointer FIFO storage write
  always_ff @(posedge clk) begin
    if (commit_pend) begin
      pmem[p_wp] <= commit_desc;
    end
  end

  // Pointer FIFO pointers, occupancy and registered read data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_wp          <= '0;
      p_rp          <= '0;
      p_cnt         <= '0;
      ptr_fifo_dout <= '0;
    end else begin
      if (commit_pend) begin
        p_wp <= p_wp + 1'b1;
      end
      if (p_rd_ok) begin
        p_rp          <= p_rp + 1'b1;
        ptr_fifo_dout <= pmem[p_rp];
      end
      p_cnt <= p_cnt + {{PTR_AW{1'b0}}, commit_pend} - {{PTR_AW{1'b0}}, p_rd_ok};
    end
  end

endmodule

// File: tb/tb_port_rx_frame_buf.sv
// Directed bench for port_rx_frame_buf: frames in, descriptors and bytes read back.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
// Status pulses are counted on the falling edge.
module tb_port_rx_frame_buf;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_last, in_err;
  logic [7:0]  in_data;
  logic        data_fifo_rd, ptr_fifo_rd;
  logic [7:0]  data_fifo_dout;
  logic [15:0] ptr_fifo_dout;
  logic        ptr_fifo_empty, stat_drop, stat_err;

  int n_chk = 0;
  int n_err = 0;
  int err_pulses = 0;
  int drop_pulses = 0;
  logic [7:0] fb [0:2047];

  port_rx_frame_buf dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_err(in_err),
    .data_fifo_rd(data_fifo_rd), .data_fifo_dout(data_fifo_dout),
    .ptr_fifo_rd(ptr_fifo_rd), .ptr_fifo_dout(ptr_fifo_dout), .ptr_fifo_empty(ptr_fifo_empty),
    .stat_drop(stat_drop), .stat_err(stat_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (stat_err)  err_pulses++;
    if (stat_drop) drop_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int seed, input int len);
    for (int i = 0; i < len; i++) fb[i] = 8'(seed * 7 + i * 3 + 1);
  endtask

  task automatic send_frame(input int len, input int err_idx);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = fb[i];
      in_last  = (i == len - 1);
      in_err   = (i == err_idx);
    end
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
    end
  endtask

  // Called right after the last byte is driven, with the descriptor FIFO empty.
  task automatic end_frame(input string tag, input logic serr);
    idle_cyc(1);
    chk({tag, "_serr"}, stat_err, serr);
    chk({tag, "_empty_before"}, ptr_fifo_empty, 1'b1);
    idle_cyc(1);
    chk({tag, "_empty_after"}, ptr_fifo_empty, 1'b0);
    chk({tag, "_serr_end"}, stat_err, 1'b0);
  endtask

  task automatic pop_ptr(input string tag, input logic [15:0] exp);
    @(posedge clk); #1 ptr_fifo_rd = 1'b1;
    @(posedge clk); #1 ptr_fifo_rd = 1'b0;
    chk(tag, ptr_fifo_dout, exp);
  endtask

  task automatic read_data(input string tag, input int n);
    int bad;
    bad = 0;
    @(posedge clk); #1 data_fifo_rd = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == n - 1) data_fifo_rd = 1'b0;
      if (data_fifo_dout !== fb[i]) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic pop_data_once(input string tag, input logic [7:0] exp);
    @(posedge clk); #1 data_fifo_rd = 1'b1;
    @(posedge clk); #1 data_fifo_rd = 1'b0;
    chk(tag, data_fifo_dout, exp);
  endtask

`ifdef RX_FCS_CHECK_EN
  task automatic add_fcs(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, fb[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) fb[n + k] = c[8*k +: 8];
  endtask
`endif

  initial begin
    rstn = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0; in_data = 8'h00;
    data_fifo_rd = 1'b0; ptr_fifo_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", ptr_fifo_empty, 1'b1);
    chk("rst_ddout", data_fifo_dout, 8'h00);
    chk("rst_pdout", ptr_fifo_dout, 16'h0000);
    chk("rst_drop", stat_drop, 1'b0);
    chk("rst_serr", stat_err, 1'b0);
    @(posedge clk); #1 rstn = 1'b1;
    idle_cyc(2);

    // 64-byte clean frame
    fill(1, 64); send_frame(64, -1); end_frame("t1", 1'b0);
    pop_ptr("t1_desc", 16'h0040);
    chk("t1_empty_pop", ptr_fifo_empty, 1'b1);
    read_data("t1_data", 64);
    chk("t1_errcnt", err_pulses, 0);

    // 60-byte runt with MAC error on byte 10
    fill(2, 60); send_frame(60, 10); end_frame("t2", 1'b1);
    pop_ptr("t2_desc", 16'hC03C);
    read_data("t2_data", 60);
    chk("t2_errcnt", err_pulses, 1);

    // 1600-byte giant: 1522 stored, tail discarded
    fill(3, 1600); send_frame(1600, -1); end_frame("t3", 1'b1);
    pop_ptr("t3_desc", 16'h45F2);
    read_data("t3_data", 1522);
    pop_data_once("t3_hold", fb[1521]);
    chk("t3_errcnt", err_pulses, 2);

    // Fill data FIFO to 3000 bytes, then a frame that must be dropped
    fill(4, 1500); send_frame(1500, -1); idle_cyc(2);
    send_frame(1500, -1); idle_cyc(2);
    fill(5, 64); send_frame(64, -1); idle_cyc(4);
    chk("t4_dropcnt", drop_pulses, 1);
    fill(4, 1500);
    pop_ptr("t4_desc_a", 16'h05DC);
    pop_ptr("t4_desc_b", 16'h05DC);
    chk("t4_no_3rd_desc", ptr_fifo_empty, 1'b1);
    read_data("t4_data_a", 1500);
    read_data("t4_data_b", 1500);
    pop_data_once("t4_no_drop_data", fb[1499]);
    fill(6, 64); send_frame(64, -1); end_frame("t4r", 1'b0);
    pop_ptr("t4r_desc", 16'h0040);
    read_data("t4r_data", 64);
    chk("t4_dropcnt_end", drop_pulses, 1);

    // Two 64-byte frames back to back with zero gap
    fill(7, 64); send_frame(64, -1); send_frame(64, -1); idle_cyc(3);
    pop_ptr("t5_desc_a", 16'h0040);
    pop_ptr("t5_desc_b", 16'h0040);
    chk("t5_empty", ptr_fifo_empty, 1'b1);
    read_data("t5_data_a", 64);
    read_data("t5_data_b", 64);
    chk("t5_errcnt", err_pulses, 2);

    // Single-byte frame: length error
    fill(8, 1); send_frame(1, -1); end_frame("t6", 1'b1);
    pop_ptr("t6_desc", 16'h4001);
    read_data("t6_data", 1);
    chk("t6_errcnt", err_pulses, 3);

    // 70-byte frame with gaps carrying unqualified in_last/in_err
    fill(9, 70);
    for (int i = 0; i < 70; i++) begin
      if (i % 10 == 5) begin
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b1; in_err = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = fb[i]; in_last = (i == 69); in_err = 1'b0;
    end
    end_frame("t7", 1'b0);
    pop_ptr("t7_desc", 16'h0046);
    read_data("t7_data", 70);

    // Reset in the middle of a frame
    fill(10, 64);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = fb[i]; in_last = 1'b0; in_err = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rstn = 1'b0;
    #2;
    chk("t8_rst_ddout", data_fifo_dout, 8'h00);
    chk("t8_rst_pdout", ptr_fifo_dout, 16'h0000);
    chk("t8_rst_empty", ptr_fifo_empty, 1'b1);
    @(posedge clk); #1 rstn = 1'b1;
    fill(11, 64); send_frame(64, -1); end_frame("t8", 1'b0);
    pop_ptr("t8_desc", 16'h0040);
    read_data("t8_data", 64);
    pop_data_once("t8_hold", fb[63]);

`ifdef RX_FCS_CHECK_EN
    // Valid FCS, then one corrupted payload byte
    fill(12, 60); add_fcs(60); send_frame(64, -1); end_frame("t9", 1'b0);
    pop_ptr("t9_desc", 16'h0040);
    read_data("t9_data", 64);
    fb[5] = fb[5] ^ 8'h01; send_frame(64, -1); end_frame("t9b", 1'b1);
    pop_ptr("t9b_desc", 16'h8040);
    read_data("t9b_data", 64);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
